uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: serial 8N1 line in, parallel byte out over a valid/ready handshake.
- Generates its own oversampling tick (OVERSAMPLE x baud) from the system clock, re-phased on every start bit.
- Detects false starts, framing errors and overruns.
- Sits between the external RX pin and the byte consumer, as the receive counterpart of the baud/transmit path.

Parameters:
SYSTEM_CLOCK_FREQ, 100000000, clk frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit period; even, >= 4
DATA_BITS, 8, data bits per frame, LSB first; range 5..8

Ports:
clk  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous, active-low reset
rx  input  1  serial line, asynchronous to clk; idle high
data  output  DATA_BITS  received byte; stable while valid=1
valid  output  1  data holds an unconsumed byte
ready  input  1  consumer accepts data when valid&&ready at posedge
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because valid&&!ready

Behaviour:
- Reset values (async on reset_n=0): data=0, valid=0, frame_err=0, overrun=0, state=IDLE, synchroniser flops=1, counters=0. Reset mid-frame abandons the frame; no outputs are produced for it.
- Synchroniser: rx passes through 2 flops (rx_s). All decisions use rx_s only.
- Tick generator: TICK_DIV = SYSTEM_CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation, minimum 1. Counter counts 0..TICK_DIV-1; tick is high for one clk at wrap. The counter is forced to 0 on the IDLE->START transition.
- FSM states:
  - IDLE: when rx_s=0 -> START; tick counter and sample counter are cleared.
  - START: count ticks. At tick number OVERSAMPLE/2 (mid start bit): rx_s=0 -> DATA with sample counter=0 and bit index=0; rx_s=1 -> false start, back to IDLE with no outputs.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift register bit [index], LSB first. After DATA_BITS samples -> STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - rx_s=1: frame good -> deliver, then IDLE.
    - rx_s=0: frame_err pulses one cycle, byte discarded -> WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s=1, then IDLE. A held-low break yields exactly one frame_err.
- Deliver, on the clk after the stop sample:
  - valid=0: data<=shift, valid<=1.
  - valid=1 and ready=1 in the same cycle: data<=shift, valid stays 1, no overrun.
  - valid=1 and ready=0: data and valid unchanged; overrun pulses one cycle.
- Handshake: valid&&ready at a posedge with no delivery that cycle -> valid<=0. valid never drops without ready. ready while valid=0 is ignored.
- Latency: valid rises 1 clk after the clk edge on which the stop bit is sampled. rx edge to rx_s is 2 clk.
- Bytes are sampled mid-bit, so tolerance to baud mismatch is about ±(OVERSAMPLE/2-1)/OVERSAMPLE of a bit over the whole frame.
- frame_err and overrun never assert in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH)
  - default SYSTEM_CLOCK_FREQ and BAUD_RATE constants
  - TICK_DIV computation function (shared with the transmitter)
- One sub-module: uart_tick_gen. Parameters: divider. Ports: clk, reset_n, clear input, tick output. Instantiated once here; reusable by the transmit path.

Test Plan (SYSTEM_CLOCK_FREQ=3200000, BAUD_RATE=100000, OVERSAMPLE=16 -> TICK_DIV=2, bit=32 clk):
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop), ready held 1 -> valid high for exactly 1 clk with data=0xA5, no flags; valid rises 1 clk after the stop sample.
- Glitch: rx low for 8 clk then high -> no valid, no frame_err, FSM back in IDLE; a following 0x3C frame is received correctly.
- 0x55 with stop bit driven 0 and rx held low for 200 clk -> exactly one frame_err pulse, valid stays 0; the next good frame 0x81 is delivered.
- ready=0, frames 0x11 then 0x22 back-to-back -> data=0x11, valid=1, one overrun pulse at the end of 0x22. Raise ready -> valid drops next clk.
- valid=1 with 0x11 and ready asserted exactly on the delivery cycle of 0x22 -> data=0x22, valid stays 1, no overrun.
- reset_n pulsed low mid-DATA of 0xFF -> all outputs 0 immediately, async. After release, the remaining bits produce no valid; next frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   uart_state_e   - receiver frame state
//   DEFAULT_*      - default system clock and line rate
//   calc_tick_div  - system clocks per oversampling tick (truncated, minimum 1)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  localparam int DEFAULT_SYSTEM_CLOCK_FREQ = 100000000;
  localparam int DEFAULT_BAUD_RATE         = 115200;

  function automatic int calc_tick_div(input int clk_freq, input int baud, input int oversample);
    int div;
    div = clk_freq / (baud * oversample);
    if (div < 1) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divider producing one-clk oversampling ticks.
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   clear_i  - forces the divider back to 0 (re-phases ticks)
//   tick_o   - high for one clk when the divider wraps
module uart_tick_gen #(
  parameter int DIVIDER = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDER - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == LAST);
  assign tick_o = wrap;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with valid/ready byte output.
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   rx         - serial line (asynchronous, idle high)
//   data       - received byte, stable while valid
//   valid      - data holds an unconsumed byte
//   ready      - consumer takes data when valid && ready at posedge
//   frame_err  - one-clk pulse: stop bit sampled low
//   overrun    - one-clk pulse: completed byte dropped (valid && !ready)
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYSTEM_CLOCK_FREQ = DEFAULT_SYSTEM_CLOCK_FREQ,
  parameter int BAUD_RATE         = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE        = 16,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TICK_DIV = calc_tick_div(SYSTEM_CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int IDX_W    = $clog2(DATA_BITS);
  localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [OS_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_ok_q, stop_ok_d;
  logic                 frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, clear_tick;

  // Holding the divider cleared throughout IDLE re-phases ticks to the start edge.
  uart_tick_gen #(.DIVIDER(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear_tick),
    .tick_o  (tick)
  );

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    stop_ok_d   = 1'b0;
    frame_err_d = 1'b0;
    clear_tick  = 1'b0;
    case (state_q)
      IDLE: begin
        clear_tick = 1'b1;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        if (!rx_s_q) state_d = START;
      end
      START: if (tick) begin
        // Mid start bit: a high line here means the low was only a glitch.
        if (tick_cnt_q == HALF_LAST) begin
          tick_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = rx_s_q ? IDLE : DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + OS_W'(1);
        end
      end
      DATA: if (tick) begin
        if (tick_cnt_q == FULL_LAST) begin
          tick_cnt_d         = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == LAST_IDX) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + IDX_W'(1);
        end else begin
          tick_cnt_d = tick_cnt_q + OS_W'(1);
        end
      end
      STOP: if (tick) begin
        if (tick_cnt_q == FULL_LAST) begin
          tick_cnt_d = '0;
          if (rx_s_q) begin
            stop_ok_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + OS_W'(1);
        end
      end
      // A held-low break must not be mistaken for a new start bit.
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Delivery one clk after a good stop sample; shift_q cannot change meanwhile.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (stop_ok_q) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      stop_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      stop_ok_q   <= stop_ok_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_F   = 3200000;
  localparam int BAUD    = 100000;
  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int BIT_CLK = 32;
  // rx fall -> 2 sync flops -> IDLE detect (3 clk), then 8 + 9*16 ticks of
  // 2 clk to the stop sample (edge 307); valid rises on the next edge.
  localparam int VALID_LAT = 308;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          ready = 1'b0;
  logic [DB-1:0] data;
  logic          valid, frame_err, overrun;

  uart_rx #(
    .SYSTEM_CLOCK_FREQ(CLK_F), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int fe_cnt = 0, ov_cnt = 0, vcyc = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_err)            fe_cnt   <= fe_cnt + 1;
      if (overrun)              ov_cnt   <= ov_cnt + 1;
      if (valid)                vcyc     <= vcyc + 1;
      if (frame_err && overrun) both_cnt <= both_cnt + 1;
    end
  end

  int n_checks = 0, n_pass = 0;
  logic [DB-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; returns on the negedge that ends the stop bit.
  task automatic drive_frame(input logic [DB-1:0] b, input logic stop_v, input int stop_len);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop_v;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int waited);
    waited = 0;
    while (!valid && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic send_and_check(input logic [DB-1:0] b, input string name);
    int w;
    logic [DB-1:0] e;
    ready = 1'b1;
    exp_q.push_back(b);
    fork
      drive_frame(b, 1'b1, BIT_CLK);
      begin
        wait_valid(400, w);
        n_checks++;
        if (w >= 400) $display("FAIL %s_timeout: valid=%b after %0d clk, required 1", name, valid, w);
        else n_pass++;
        if (w < 400) begin
          e = exp_q.pop_front();
          n_checks++;
          if (data !== e) $display("FAIL %s_data: got %02h required %02h", name, data, e);
          else n_pass++;
        end
      end
    join
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (data !== 8'h00 || valid !== 1'b0) $display("FAIL reset_out: data=%02h valid=%b required 00/0", data, valid);
    else n_pass++;
    n_checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL reset_flags: fe=%b ov=%b required 0/0", frame_err, overrun);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE || dut.rx_s_q !== 1'b1) $display("FAIL reset_state: state=%0d rx_s=%b required IDLE/1", dut.state_q, dut.rx_s_q);
    else n_pass++;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) $display("FAIL reset_idle_valid: got %b required 0", valid);
    else n_pass++;
  endtask

  task automatic test_single();
    int t0, w, fe0, ov0;
    logic [DB-1:0] e;
    ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    t0 = cyc;
    fork
      drive_frame(8'hA5, 1'b1, BIT_CLK);
      begin
        wait_valid(400, w);
        n_checks++;
        if (cyc - t0 != VALID_LAT) $display("FAIL single_latency: valid at %0d clk, required %0d", cyc - t0, VALID_LAT);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (data !== e) $display("FAIL single_data: got %02h required %02h", data, e);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) $display("FAIL single_pulse: valid=%b one clk later, required 0", valid);
        else n_pass++;
      end
    join
    repeat (5) @(negedge clk);
    n_checks++;
    if (fe_cnt != fe0 || ov_cnt != ov0) $display("FAIL single_flags: fe=%0d ov=%0d pulses, required 0/0", fe_cnt - fe0, ov_cnt - ov0);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int fe0, v0;
    fe0 = fe_cnt; v0 = vcyc;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (vcyc != v0 || fe_cnt != fe0) $display("FAIL glitch_outputs: valid cycles=%0d fe=%0d, required 0/0", vcyc - v0, fe_cnt - fe0);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL glitch_state: got %0d required IDLE", dut.state_q);
    else n_pass++;
    send_and_check(8'h3C, "glitch_next");
  endtask

  task automatic test_break();
    int fe0, v0;
    ready = 1'b1;
    fe0 = fe_cnt; v0 = vcyc;
    drive_frame(8'h55, 1'b0, 200);
    repeat (5) @(negedge clk);
    n_checks++;
    if (fe_cnt - fe0 != 1) $display("FAIL break_frame_err: got %0d pulses required 1", fe_cnt - fe0);
    else n_pass++;
    n_checks++;
    if (vcyc != v0) $display("FAIL break_valid: got %0d valid cycles required 0", vcyc - v0);
    else n_pass++;
    send_and_check(8'h81, "break_next");
  endtask

  task automatic test_back_to_back();
    int ov0;
    logic [DB-1:0] e;
    ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    drive_frame(8'h11, 1'b1, BIT_CLK);
    drive_frame(8'h22, 1'b1, BIT_CLK);
    repeat (4) @(negedge clk);
    n_checks++;
    if (ov_cnt - ov0 != 1) $display("FAIL b2b_overrun: got %0d pulses required 1", ov_cnt - ov0);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b1) $display("FAIL b2b_valid: got %b required 1", valid);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (data !== e) $display("FAIL b2b_data: got %02h required %02h", data, e);
    else n_pass++;
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) $display("FAIL b2b_drop: valid=%b after ready, required 0", valid);
    else n_pass++;
    ready = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ready_on_delivery();
    int ov0;
    logic [DB-1:0] e;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    drive_frame(8'h11, 1'b1, BIT_CLK);
    repeat (5) @(negedge clk);
    ov0 = ov_cnt;
    fork
      drive_frame(8'h22, 1'b1, BIT_CLK);
      begin
        repeat (VALID_LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        void'(exp_q.pop_front());  // 0x11 taken on the delivery edge
        #1;
        ready = 1'b0;
        e = exp_q[0];
        n_checks++;
        if (data !== e || valid !== 1'b1) $display("FAIL deliv_data: data=%02h valid=%b required %02h/1", data, valid, e);
        else n_pass++;
      end
    join
    repeat (3) @(negedge clk);
    n_checks++;
    if (ov_cnt != ov0) $display("FAIL deliv_overrun: got %0d pulses required 0", ov_cnt - ov0);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b1 || data !== 8'h22) $display("FAIL deliv_hold: data=%02h valid=%b required 22/1", data, valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    fork
      drive_frame(8'hFF, 1'b1, BIT_CLK);
      begin
        repeat (100) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (data !== 8'h00 || valid !== 1'b0) $display("FAIL rst_mid_out: data=%02h valid=%b required 00/0", data, valid);
        else n_pass++;
        n_checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) $display("FAIL rst_mid_flags: fe=%b ov=%b required 0/0", frame_err, overrun);
        else n_pass++;
        exp_q.delete();  // the pending byte is abandoned by reset
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
      end
    join
    v0 = vcyc;
    repeat (20) @(negedge clk);
    n_checks++;
    if (vcyc != v0) $display("FAIL rst_mid_valid: got %0d valid cycles required 0", vcyc - v0);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL rst_mid_state: got %0d required IDLE", dut.state_q);
    else n_pass++;
    send_and_check(8'h0F, "rst_next");
  endtask

  task automatic test_flags_exclusive();
    n_checks++;
    if (both_cnt != 0) $display("FAIL flags_exclusive: %0d cycles with both, required 0", both_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_back_to_back();
    test_ready_on_delivery();
    test_reset_mid_frame();
    test_flags_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
